regfile_rr_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 8x16 single-port register file. It accepts independent read/write requests from ports A and B and serialises them into one-cycle RF_WrEn/RF_RdEn strobes. It captures the register file's registered read data and returns it to the owning requester with a Done pulse. It sits between two client blocks (e.g. a host bus slave and a DMA engine) and the register file instance.

---
 rtl/regfile_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rr_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the 8x16 single-port
// register file. Requests from ports A and B are serialised into one-cycle
// RF_WrEn/RF_RdEn strobes. Read data is returned to the owner with a Done pulse.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | sample Req_A/Req_B, grant one, latch its op/addr/data
// ISSUE  | one-cycle RF_WrEn or RF_RdEn strobe with the latched op
// RDWAIT | RF_RdData valid; copy it into the owner's RData register
// DONE   | one-cycle Done pulse to the owner, no sampling
module regfile_rr_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Req_A,
   input  logic              Wr_A,
   input  logic [ADDR_W-1:0] Addr_A,
   input  logic [DATA_W-1:0] WData_A,
   output logic              Done_A,
   output logic [DATA_W-1:0] RData_A,
   input  logic              Req_B,
   input  logic              Wr_B,
   input  logic [ADDR_W-1:0] Addr_B,
   input  logic [DATA_W-1:0] WData_B,
   output logic              Done_B,
   output logic [DATA_W-1:0] RData_B,
   output logic              Busy,
   output logic              RF_WrEn,
   output logic              RF_RdEn,
   output logic [ADDR_W-1:0] RF_Address,
   output logic [DATA_W-1:0] RF_WrData,
   input  logic [DATA_W-1:0] RF_RdData
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   state_t              state;
   state_t              state_nxt;
   logic                last_grant;
   logic                last_grant_nxt;
   logic                owner;
   logic                owner_nxt;
   logic                op_wr;
   logic                op_wr_nxt;
   logic                pick_b;

   logic                rf_wren_nxt;
   logic                rf_rden_nxt;
   logic [ADDR_W-1:0]   rf_address_nxt;
   logic [DATA_W-1:0]   rf_wrdata_nxt;
   logic                done_a_nxt;
   logic                done_b_nxt;
   logic [DATA_W-1:0]   rdata_a_nxt;
   logic [DATA_W-1:0]   rdata_b_nxt;
   logic                busy_nxt;

   // Next-state and next-output decode; every output is registered below,
   // so the strobes computed here appear in the cycle after the decision.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      owner_nxt      = owner;
      op_wr_nxt      = op_wr;
      rf_wren_nxt    = 1'b0;
      rf_rden_nxt    = 1'b0;
      rf_address_nxt = RF_Address;
      rf_wrdata_nxt  = RF_WrData;
      done_a_nxt     = 1'b0;
      done_b_nxt     = 1'b0;
      rdata_a_nxt    = RData_A;
      rdata_b_nxt    = RData_B;

      // On a tie the requester that did not win last time is chosen.
      if (Req_A && Req_B) begin
         pick_b = (last_grant == SEL_A);
      end else begin
         pick_b = Req_B;
      end

      case (state)
         IDLE: begin
            if (Req_A || Req_B) begin
               owner_nxt      = pick_b;
               last_grant_nxt = pick_b;
               if (pick_b) begin
                  op_wr_nxt      = Wr_B;
                  rf_address_nxt = Addr_B;
                  rf_wrdata_nxt  = WData_B;
               end else begin
                  op_wr_nxt      = Wr_A;
                  rf_address_nxt = Addr_A;
                  rf_wrdata_nxt  = WData_A;
               end
               rf_wren_nxt = op_wr_nxt;
               rf_rden_nxt = ~op_wr_nxt;
               state_nxt   = ISSUE;
            end
         end
         ISSUE: begin
            if (op_wr) begin
               done_a_nxt = (owner == SEL_A);
               done_b_nxt = (owner == SEL_B);
               state_nxt  = DONE;
            end else begin
               state_nxt = RDWAIT;
            end
         end
         RDWAIT: begin
            if (owner == SEL_B) begin
               rdata_b_nxt = RF_RdData;
            end else begin
               rdata_a_nxt = RF_RdData;
            end
            done_a_nxt = (owner == SEL_A);
            done_b_nxt = (owner == SEL_B);
            state_nxt  = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers with synchronous active-high reset; reset
   // drops any in-flight operation and re-arms A to win the first tie.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_grant <= SEL_B;
         owner      <= SEL_A;
         op_wr      <= 1'b0;
         RF_WrEn    <= 1'b0;
         RF_RdEn    <= 1'b0;
         RF_Address <= '0;
         RF_WrData  <= '0;
         Done_A     <= 1'b0;
         Done_B     <= 1'b0;
         RData_A    <= '0;
         RData_B    <= '0;
         Busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         owner      <= owner_nxt;
         op_wr      <= op_wr_nxt;
         RF_WrEn    <= rf_wren_nxt;
         RF_RdEn    <= rf_rden_nxt;
         RF_Address <= rf_address_nxt;
         RF_WrData  <= rf_wrdata_nxt;
         Done_A     <= done_a_nxt;
         Done_B     <= done_b_nxt;
         RData_A    <= rdata_a_nxt;
         RData_B    <= rdata_b_nxt;
         Busy       <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Directed bench for regfile_rr_arbiter with a behavioural 8x16 register
// file (registered read) attached to the RF_* side.
module tb_regfile_rr_arbiter;

   logic        CLK;
   logic        RST;
   logic        Req_A, Wr_A, Done_A;
   logic [2:0]  Addr_A;
   logic [15:0] WData_A, RData_A;
   logic        Req_B, Wr_B, Done_B;
   logic [2:0]  Addr_B;
   logic [15:0] WData_B, RData_B;
   logic        Busy, RF_WrEn, RF_RdEn;
   logic [2:0]  RF_Address;
   logic [15:0] RF_WrData, RF_RdData;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int overlap  = 0;
   int both_done = 0;
   int done_log[$];
   int done_cyc[$];

   logic [15:0] rf_mem [8];
   logic [15:0] rf_rd;

   regfile_rr_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Req_A      (Req_A),
      .Wr_A       (Wr_A),
      .Addr_A     (Addr_A),
      .WData_A    (WData_A),
      .Done_A     (Done_A),
      .RData_A    (RData_A),
      .Req_B      (Req_B),
      .Wr_B       (Wr_B),
      .Addr_B     (Addr_B),
      .WData_B    (WData_B),
      .Done_B     (Done_B),
      .RData_B    (RData_B),
      .Busy       (Busy),
      .RF_WrEn    (RF_WrEn),
      .RF_RdEn    (RF_RdEn),
      .RF_Address (RF_Address),
      .RF_WrData  (RF_WrData),
      .RF_RdData  (RF_RdData)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // register file model: write on strobe, read data registered
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
      if (RF_RdEn) rf_rd <= rf_mem[RF_Address];
   end
   assign RF_RdData = rf_rd;

   // strobes and Done pulses must never coincide
   always @(negedge CLK) begin
      if (RF_WrEn && RF_RdEn) overlap <= overlap + 1;
      if (Done_A && Done_B) both_done <= both_done + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      Req_A = 1'b0;
      Req_B = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   // Run both ports (already configured) until n_ops Done pulses are seen.
   task automatic run_pair(input int n_ops, input bit drop_on_done);
      int c;
      done_log.delete();
      done_cyc.delete();
      c = 0;
      while (c < 200 && done_log.size() < n_ops) begin
         tick();
         if (Done_A) begin
            done_log.push_back(0);
            done_cyc.push_back(cyc);
            if (drop_on_done) Req_A = 1'b0;
         end
         if (Done_B) begin
            done_log.push_back(1);
            done_cyc.push_back(cyc);
            if (drop_on_done) Req_B = 1'b0;
         end
         c++;
      end
      Req_A = 1'b0;
      Req_B = 1'b0;
      check_eq("pair_done_count", done_log.size(), n_ops);
      tick();
   endtask

   task automatic single_op(input bit port_b, input bit wr, input logic [2:0] addr,
                            input logic [15:0] wd);
      int seen;
      seen = 0;
      if (port_b) begin
         Req_B = 1'b1; Wr_B = wr; Addr_B = addr; WData_B = wd;
      end else begin
         Req_A = 1'b1; Wr_A = wr; Addr_A = addr; WData_A = wd;
      end
      for (int c = 0; c < 10 && seen == 0; c++) begin
         tick();
         if (port_b ? Done_B : Done_A) seen = 1;
      end
      Req_A = 1'b0;
      Req_B = 1'b0;
      check_eq("single_op_done", seen, 1);
      tick();
   endtask

   initial begin
      int cnt;
      RST = 1'b1;
      Req_A = 1'b0; Wr_A = 1'b0; Addr_A = '0; WData_A = '0;
      Req_B = 1'b0; Wr_B = 1'b0; Addr_B = '0; WData_B = '0;
      do_reset();

      // reset values
      check_eq("rst_busy", Busy, 0);
      check_eq("rst_wren", RF_WrEn, 0);
      check_eq("rst_rden", RF_RdEn, 0);
      check_eq("rst_addr", RF_Address, 0);
      check_eq("rst_wdata", RF_WrData, 0);
      check_eq("rst_done_a", Done_A, 0);
      check_eq("rst_done_b", Done_B, 0);
      check_eq("rst_rdata_a", RData_A, 0);
      check_eq("rst_rdata_b", RData_B, 0);

      // 1: A writes BEEF to addr 3
      Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 3'd3; WData_A = 16'hBEEF;
      tick();
      check_eq("t1_wren", RF_WrEn, 1);
      check_eq("t1_rden", RF_RdEn, 0);
      check_eq("t1_addr", RF_Address, 3);
      check_eq("t1_wdata", RF_WrData, 16'hBEEF);
      check_eq("t1_busy", Busy, 1);
      check_eq("t1_done_early", Done_A, 0);
      tick();
      check_eq("t1_wren_off", RF_WrEn, 0);
      check_eq("t1_done_a", Done_A, 1);
      check_eq("t1_done_b", Done_B, 0);
      Req_A = 1'b0;
      tick();
      check_eq("t1_done_a_off", Done_A, 0);
      check_eq("t1_idle", Busy, 0);

      // 2: B reads addr 3
      Req_B = 1'b1; Wr_B = 1'b0; Addr_B = 3'd3;
      tick();
      check_eq("t2_rden", RF_RdEn, 1);
      check_eq("t2_wren", RF_WrEn, 0);
      check_eq("t2_addr", RF_Address, 3);
      tick();
      check_eq("t2_rden_off", RF_RdEn, 0);
      check_eq("t2_done_early", Done_B, 0);
      tick();
      check_eq("t2_done_b", Done_B, 1);
      check_eq("t2_rdata_b", RData_B, 16'hBEEF);
      check_eq("t2_rdata_a", RData_A, 0);
      check_eq("t2_done_a", Done_A, 0);
      Req_B = 1'b0;
      tick();
      check_eq("t2_done_b_off", Done_B, 0);
      check_eq("t2_idle", Busy, 0);

      // 3: tie from reset, both write addr 5
      do_reset();
      Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 3'd5; WData_A = 16'h0001;
      Req_B = 1'b1; Wr_B = 1'b1; Addr_B = 3'd5; WData_B = 16'h0002;
      run_pair(2, 1'b1);
      for (int i = 0; i < done_log.size(); i++)
         check_eq($sformatf("t3_order%0d", i), done_log[i], i);
      single_op(1'b0, 1'b0, 3'd5, 16'h0);
      check_eq("t3_rdata_a", RData_A, 16'h0002);

      // 4: both hold Req for 6 ops: A writes addr 1, B reads addr 1
      do_reset();
      Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 3'd1; WData_A = 16'h00A5;
      Req_B = 1'b1; Wr_B = 1'b0; Addr_B = 3'd1;
      run_pair(6, 1'b0);
      for (int i = 0; i < done_log.size(); i++)
         check_eq($sformatf("t4_order%0d", i), done_log[i], i % 2);
      for (int i = 0; i + 1 < done_cyc.size(); i++)
         check_eq($sformatf("t4_gap%0d", i), done_cyc[i+1] - done_cyc[i], (i % 2 == 0) ? 4 : 3);
      check_eq("t4_rdata_b", RData_B, 16'h00A5);
      check_eq("t4_overlap", overlap, 0);
      check_eq("t4_both_done", both_done, 0);

      // 5: input changes and Req drop during ISSUE are ignored
      Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 3'd6; WData_A = 16'h5A5A;
      tick();
      check_eq("t5_wren", RF_WrEn, 1);
      check_eq("t5_wdata", RF_WrData, 16'h5A5A);
      check_eq("t5_addr", RF_Address, 6);
      WData_A = 16'h1111;
      Req_A = 1'b0;
      cnt = 0;
      repeat (6) begin
         tick();
         if (Done_A) cnt++;
      end
      check_eq("t5_done_count", cnt, 1);
      single_op(1'b1, 1'b0, 3'd6, 16'h0);
      check_eq("t5_rdata_b", RData_B, 16'h5A5A);

      // 6: reset during RDWAIT of a B read
      Req_B = 1'b1; Wr_B = 1'b0; Addr_B = 3'd6;
      tick();
      check_eq("t6_rden", RF_RdEn, 1);
      tick();
      check_eq("t6_busy_rdwait", Busy, 1);
      RST = 1'b1;
      Req_B = 1'b0;
      tick();
      check_eq("t6_busy", Busy, 0);
      check_eq("t6_wren", RF_WrEn, 0);
      check_eq("t6_rden_off", RF_RdEn, 0);
      check_eq("t6_done_b", Done_B, 0);
      check_eq("t6_rdata_b", RData_B, 0);
      RST = 1'b0;
      tick();
      check_eq("t6_done_b_after", Done_B, 0);
      check_eq("t6_idle", Busy, 0);
      Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 3'd0; WData_A = 16'h0A0A;
      Req_B = 1'b1; Wr_B = 1'b1; Addr_B = 3'd0; WData_B = 16'h0B0B;
      run_pair(2, 1'b1);
      if (done_log.size() > 0) check_eq("t6_first_grant", done_log[0], 0);
      check_eq("t6_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

endmodule
